// File: rtl/exe_pkg.sv
// Shared encodings for the MIPS execute stage:
// ALU/MD opcodes, control-word fields, divider states.
package exe_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADDU = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SUBU = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_SLL  = 4'd10;
  localparam logic [3:0] ALU_SRL  = 4'd11;
  localparam logic [3:0] ALU_SRA  = 4'd12;
  localparam logic [3:0] ALU_LUI  = 4'd13;
  localparam logic [3:0] ALU_MFHI = 4'd14;
  localparam logic [3:0] ALU_MFLO = 4'd15;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int CW_ALU_HI = 23;
  localparam int CW_ALU_LO = 20;
  localparam int CW_MD_HI  = 26;
  localparam int CW_MD_LO  = 24;
  localparam int CW_LOAD   = 8;
  localparam int CW_STORE  = 7;

  localparam int OVF_BIT = 3;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  function automatic logic [31:0] neg_if(
    input logic        n,
    input logic [31:0] v
  );
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/exe_divider.sv
// Iterative restoring divider, one quotient bit per cycle,
// magnitude datapath with sign fix-up on the way out.
module exe_divider
  import exe_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic        abort_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      quo_q, quo_d;
  logic [31:0]      dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             a_neg, b_neg;
  logic [32:0]      trial, diff;

  assign a_neg = signed_i & a_i[31];
  assign b_neg = signed_i & b_i[31];
  // dividend bits shift out of the quotient register into the remainder
  assign trial = {rem_q, quo_q[31]};
  assign diff  = trial - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          state_d = DIV_RUN;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = neg_if(a_neg, a_i);
          dvs_d   = neg_if(b_neg, b_i);
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          dz_d    = (b_i == 32'd0);
        end
      end
      DIV_RUN: begin
        rem_d = diff[32] ? trial[31:0] : diff[31:0];
        quo_d = {quo_q[30:0], ~diff[32]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = DIV_DONE;
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (abort_i) state_d = DIV_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  assign quo_o  = dz_q ? 32'hFFFF_FFFF : neg_if(qneg_q, quo_q);
  assign rem_o  = neg_if(rneg_q, rem_q);
  assign busy_o = (state_q == DIV_RUN);
  assign done_o = (state_q == DIV_DONE);

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: ALU, HI/LO, multiplier and divider,
// producing the registered EXE/MEM bundle.
module exe_stage
  import exe_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        FLUSH,
  input  logic [31:0] CONTROLW_ID,
  input  logic [7:0]  INTCONTROLW_ID,
  input  logic [31:0] SRCA,
  input  logic [31:0] SRCB,
  input  logic [31:0] STOREDATA,
  input  logic [31:0] IDPC,
  input  logic [6:0]  IDDES,
  output logic [31:0] CONTROLW_EXE,
  output logic [7:0]  INTCONTROLW_EXE,
  output logic [31:0] ALURES,
  output logic [31:0] MEMDATA,
  output logic [31:0] MEMPC,
  output logic [31:0] MEMHILO,
  output logic [6:0]  EXEDES,
  output logic [1:0]  EXEWRITEHILO,
  output logic [31:0] EXERESULT,
  output logic        EXESTALL
);

  logic [3:0]  aluop;
  logic [2:0]  mdop;
  logic [4:0]  shamt;
  logic [31:0] sum, dif;
  logic [31:0] alu_res;
  logic        ovf;
  logic [63:0] prod_s, prod_u;
  logic        is_div, stall;
  logic [31:0] div_quo, div_rem;
  logic        div_busy, div_done;

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] cw_q, cw_d;
  logic [7:0]  intc_q, intc_d;
  logic [31:0] alures_q, alures_d;
  logic [31:0] memdata_q, memdata_d;
  logic [31:0] mempc_q, mempc_d;
  logic [31:0] memhilo_q, memhilo_d;
  logic [6:0]  des_q, des_d;
  logic [1:0]  whl_q, whl_d;

  assign aluop = CONTROLW_ID[CW_ALU_HI:CW_ALU_LO];
  assign mdop  = CONTROLW_ID[CW_MD_HI:CW_MD_LO];
  assign shamt = SRCA[4:0];
  assign sum   = SRCA + SRCB;
  assign dif   = SRCA - SRCB;

  assign prod_s = {{32{SRCA[31]}}, SRCA} * {{32{SRCB[31]}}, SRCB};
  assign prod_u = {32'd0, SRCA} * {32'd0, SRCB};

  always_comb begin
    alu_res = '0;
    ovf     = 1'b0;
    case (aluop)
      ALU_ADD: begin
        alu_res = sum;
        ovf = (SRCA[31] == SRCB[31]) && (sum[31] != SRCA[31]);
      end
      ALU_ADDU: alu_res = sum;
      ALU_SUB: begin
        alu_res = dif;
        ovf = (SRCA[31] != SRCB[31]) && (dif[31] != SRCA[31]);
      end
      ALU_SUBU: alu_res = dif;
      ALU_AND:  alu_res = SRCA & SRCB;
      ALU_OR:   alu_res = SRCA | SRCB;
      ALU_XOR:  alu_res = SRCA ^ SRCB;
      ALU_NOR:  alu_res = ~(SRCA | SRCB);
      ALU_SLT:  alu_res = {31'd0, $signed(SRCA) < $signed(SRCB)};
      ALU_SLTU: alu_res = {31'd0, SRCA < SRCB};
      ALU_SLL:  alu_res = SRCB << shamt;
      ALU_SRL:  alu_res = SRCB >> shamt;
      ALU_SRA:  alu_res = $signed(SRCB) >>> shamt;
      ALU_LUI:  alu_res = {SRCB[15:0], 16'd0};
      ALU_MFHI: alu_res = hi_q;
      ALU_MFLO: alu_res = lo_q;
      default:  alu_res = '0;
    endcase
  end

  assign is_div = (mdop == MD_DIV) || (mdop == MD_DIVU);
  // the DIV stays on the ID inputs until the divider reports done
  assign stall  = ~reset & ~FLUSH & (div_busy | (is_div & ~div_done));

  exe_divider #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start_i  (is_div & ~FLUSH),
    .signed_i (mdop == MD_DIV),
    .abort_i  (FLUSH),
    .a_i      (SRCA),
    .b_i      (SRCB),
    .quo_o    (div_quo),
    .rem_o    (div_rem),
    .busy_o   (div_busy),
    .done_o   (div_done)
  );

  always_comb begin
    cw_d      = '0;
    intc_d    = '0;
    alures_d  = '0;
    memdata_d = '0;
    mempc_d   = '0;
    memhilo_d = '0;
    des_d     = '0;
    whl_d     = '0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (!FLUSH && !stall) begin
      cw_d      = CONTROLW_ID;
      intc_d    = INTCONTROLW_ID;
      intc_d[OVF_BIT] = INTCONTROLW_ID[OVF_BIT] | ovf;
      alures_d  = alu_res;
      memdata_d = STOREDATA;
      mempc_d   = IDPC;
      des_d     = ovf ? 7'd0 : IDDES;
      unique case (mdop)
        MD_MULT: begin
          {hi_d, lo_d} = prod_s;
          whl_d = 2'b11;
        end
        MD_MULTU: begin
          {hi_d, lo_d} = prod_u;
          whl_d = 2'b11;
        end
        MD_DIV, MD_DIVU: begin
          hi_d  = div_rem;
          lo_d  = div_quo;
          whl_d = 2'b11;
        end
        MD_MTHI: begin
          hi_d      = STOREDATA;
          memhilo_d = STOREDATA;
          whl_d     = 2'b10;
        end
        MD_MTLO: begin
          lo_d      = STOREDATA;
          memhilo_d = STOREDATA;
          whl_d     = 2'b01;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      cw_q      <= '0;
      intc_q    <= '0;
      alures_q  <= '0;
      memdata_q <= '0;
      mempc_q   <= '0;
      memhilo_q <= '0;
      des_q     <= '0;
      whl_q     <= '0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cw_q      <= cw_d;
      intc_q    <= intc_d;
      alures_q  <= alures_d;
      memdata_q <= memdata_d;
      mempc_q   <= mempc_d;
      memhilo_q <= memhilo_d;
      des_q     <= des_d;
      whl_q     <= whl_d;
    end
  end

  assign CONTROLW_EXE    = cw_q;
  assign INTCONTROLW_EXE = intc_q;
  assign ALURES          = alures_q;
  assign MEMDATA         = memdata_q;
  assign MEMPC           = mempc_q;
  assign MEMHILO         = memhilo_q;
  assign EXEDES          = des_q;
  assign EXEWRITEHILO    = whl_q;
  assign EXERESULT       = alu_res;
  assign EXESTALL        = stall;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: expectations are queued
// with a target cycle, a negedge monitor pops and compares.
module tb_exe_stage;
  import exe_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        FLUSH = 1'b0;
  logic [31:0] CONTROLW_ID = '0;
  logic [7:0]  INTCONTROLW_ID = '0;
  logic [31:0] SRCA = '0;
  logic [31:0] SRCB = '0;
  logic [31:0] STOREDATA = '0;
  logic [31:0] IDPC = '0;
  logic [6:0]  IDDES = '0;
  logic [31:0] CONTROLW_EXE;
  logic [7:0]  INTCONTROLW_EXE;
  logic [31:0] ALURES;
  logic [31:0] MEMDATA;
  logic [31:0] MEMPC;
  logic [31:0] MEMHILO;
  logic [6:0]  EXEDES;
  logic [1:0]  EXEWRITEHILO;
  logic [31:0] EXERESULT;
  logic        EXESTALL;

  exe_stage #(
    .DIV_CYCLES(32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .FLUSH           (FLUSH),
    .CONTROLW_ID     (CONTROLW_ID),
    .INTCONTROLW_ID  (INTCONTROLW_ID),
    .SRCA            (SRCA),
    .SRCB            (SRCB),
    .STOREDATA       (STOREDATA),
    .IDPC            (IDPC),
    .IDDES           (IDDES),
    .CONTROLW_EXE    (CONTROLW_EXE),
    .INTCONTROLW_EXE (INTCONTROLW_EXE),
    .ALURES          (ALURES),
    .MEMDATA         (MEMDATA),
    .MEMPC           (MEMPC),
    .MEMHILO         (MEMHILO),
    .EXEDES          (EXEDES),
    .EXEWRITEHILO    (EXEWRITEHILO),
    .EXERESULT       (EXERESULT),
    .EXESTALL        (EXESTALL)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int S_CW = 0, S_IC = 1, S_RES = 2, S_MD = 3, S_PC = 4;
  localparam int S_HL = 5, S_DES = 6, S_WHL = 7, S_STL = 8, S_ER = 9;

  typedef struct {
    string       nm;
    int          at;
    int          sel;
    logic [31:0] v;
  } exp_t;

  exp_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] act;

  function automatic logic [31:0] sig(input int s);
    case (s)
      S_CW:    return CONTROLW_EXE;
      S_IC:    return {24'd0, INTCONTROLW_EXE};
      S_RES:   return ALURES;
      S_MD:    return MEMDATA;
      S_PC:    return MEMPC;
      S_HL:    return MEMHILO;
      S_DES:   return {25'd0, EXEDES};
      S_WHL:   return {30'd0, EXEWRITEHILO};
      S_STL:   return {31'd0, EXESTALL};
      default: return EXERESULT;
    endcase
  endfunction

  function automatic void expect_v(input int d, input int s,
                                   input logic [31:0] v, input string nm);
    exp_t e;
    e.nm  = nm;
    e.at  = cyc + d;
    e.sel = s;
    e.v   = v;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        n_total++;
        act = sig(sb[i].sel);
        if (act === sb[i].v) n_pass++;
        else $display("FAIL %s @cyc%0d: got %h expected %h",
                      sb[i].nm, cyc, act, sb[i].v);
        sb.delete(i);
      end
    end
  end

  function automatic logic [31:0] mk(input logic [3:0] alu,
                                     input logic [2:0] md);
    logic [31:0] w;
    w = 32'h8000_0001;
    w[CW_ALU_HI:CW_ALU_LO] = alu;
    w[CW_MD_HI:CW_MD_LO] = md;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] cw, a, b, sd, pc,
                       input logic [6:0] des, input logic [7:0] ic);
    step();
    CONTROLW_ID    = cw;
    SRCA           = a;
    SRCB           = b;
    STOREDATA      = sd;
    IDPC           = pc;
    IDDES          = des;
    INTCONTROLW_ID = ic;
  endtask

  task automatic nop();
    issue(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 7'd0, 8'd0);
  endtask

  task automatic chk_hl(input logic [31:0] h, l, input string tag);
    issue(mk(ALU_MFHI, MD_NONE), 0, 0, 0, 0, 7'd2, 8'd0);
    expect_v(0, S_ER, h, {tag, "_hi"});
    issue(mk(ALU_MFLO, MD_NONE), 0, 0, 0, 0, 7'd3, 8'd0);
    expect_v(0, S_ER, l, {tag, "_lo"});
  endtask

  task automatic alu_chk(input logic [3:0] op, input logic [31:0] a, b,
                         input logic [31:0] r, input string nm);
    issue(mk(op, MD_NONE), a, b, 0, 0, 7'd4, 8'd0);
    expect_v(1, S_RES, r, nm);
  endtask

  task automatic run_div(input logic [2:0] md, input logic [31:0] a, b,
                         input logic [31:0] lo, hi, input string tag);
    logic [31:0] cw;
    cw = mk(ALU_ADDU, md);
    issue(cw, a, b, 0, 32'h100, 7'd0, 8'd0);
    for (int k = 0; k <= 32; k++) expect_v(k, S_STL, 1, {tag, "_stall"});
    expect_v(33, S_STL, 0, {tag, "_stall_end"});
    for (int k = 1; k <= 33; k++) expect_v(k, S_CW, 0, {tag, "_bubble"});
    expect_v(34, S_CW, cw, {tag, "_cw"});
    expect_v(34, S_WHL, 32'd3, {tag, "_whl"});
    repeat (33) step();
    chk_hl(hi, lo, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    for (int s = 0; s <= 9; s++) expect_v(0, s, 0, "reset_state");
    reset = 1'b0;

    issue(mk(ALU_ADDU, MD_MTHI), 0, 0, 32'hAAAA, 0, 7'd0, 8'd0);
    expect_v(1, S_HL, 32'hAAAA, "mthi_memhilo");
    expect_v(1, S_WHL, 32'd2, "mthi_whl");
    issue(mk(ALU_ADDU, MD_MTLO), 0, 0, 32'h5555, 0, 7'd0, 8'd0);
    expect_v(1, S_HL, 32'h5555, "mtlo_memhilo");
    expect_v(1, S_WHL, 32'd1, "mtlo_whl");
    chk_hl(32'hAAAA, 32'h5555, "mt");

    issue(mk(ALU_ADDU, MD_DIV), 32'd40, 32'd3, 0, 0, 7'd0, 8'd0);
    expect_v(9, S_STL, 1, "pre_reset_stall");
    repeat (9) step();
    step();
    reset = 1'b1;
    for (int s = 0; s <= 7; s++) expect_v(1, s, 0, "mid_div_reset");
    expect_v(1, S_STL, 0, "mid_div_reset_stall");
    step();
    reset = 1'b0;
    CONTROLW_ID = '0;
    SRCA = '0;
    SRCB = '0;
    chk_hl(32'd0, 32'd0, "after_reset");

    issue(mk(ALU_ADD, MD_NONE), 32'h7FFF_FFFF, 32'd1, 0, 0, 7'd5, 8'h01);
    expect_v(0, S_ER, 32'h8000_0000, "add_ovf_fwd");
    expect_v(1, S_RES, 32'h8000_0000, "add_ovf_res");
    expect_v(1, S_DES, 0, "add_ovf_des");
    expect_v(1, S_IC, 32'h09, "add_ovf_ic");
    issue(mk(ALU_ADDU, MD_NONE), 32'h7FFF_FFFF, 32'd1, 0, 0, 7'd5, 8'h01);
    expect_v(1, S_RES, 32'h8000_0000, "addu_res");
    expect_v(1, S_DES, 32'd5, "addu_des");
    expect_v(1, S_IC, 32'h01, "addu_ic");
    issue(mk(ALU_SUB, MD_NONE), 32'h8000_0000, 32'd1, 0, 0, 7'd6, 8'h00);
    expect_v(1, S_RES, 32'h7FFF_FFFF, "sub_ovf_res");
    expect_v(1, S_DES, 0, "sub_ovf_des");
    expect_v(1, S_IC, 32'h08, "sub_ovf_ic");

    issue(mk(ALU_ADD, MD_NONE), 32'd3, 32'd4, 32'hDEAD, 32'h400, 7'd9, 8'd0);
    expect_v(0, S_ER, 32'd7, "add_fwd");
    expect_v(1, S_RES, 32'd7, "add_res");
    expect_v(1, S_MD, 32'hDEAD, "memdata");
    expect_v(1, S_PC, 32'h400, "mempc");
    expect_v(1, S_DES, 32'd9, "add_des");
    expect_v(1, S_CW, mk(ALU_ADD, MD_NONE), "add_cw");
    expect_v(1, S_HL, 0, "add_memhilo");
    alu_chk(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, "slt");
    alu_chk(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, "sltu");
    alu_chk(ALU_SRA, 32'd4, 32'h8000_0000, 32'hF800_0000, "sra");
    alu_chk(ALU_SRL, 32'd31, 32'h8000_0000, 32'd1, "srl");
    alu_chk(ALU_SLL, 32'd4, 32'd1, 32'h10, "sll");
    alu_chk(ALU_LUI, 32'd0, 32'h1234, 32'h1234_0000, "lui");
    alu_chk(ALU_NOR, 32'd0, 32'hF0, 32'hFFFF_FF0F, "nor");
    alu_chk(ALU_XOR, 32'hFF00, 32'h0FF0, 32'hF0F0, "xor");
    alu_chk(ALU_SUBU, 32'd1, 32'd2, 32'hFFFF_FFFF, "subu");

    run_div(MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_m7_2");
    run_div(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, "div_min");
    run_div(MD_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, "divu_by0");

    issue(mk(ALU_ADDU, MD_DIV), 32'd50, 32'd3, 0, 0, 7'd0, 8'd0);
    for (int k = 0; k <= 4; k++) expect_v(k, S_STL, 1, "flush_pre_stall");
    repeat (4) step();
    step();
    FLUSH = 1'b1;
    expect_v(0, S_STL, 0, "flush_stall");
    expect_v(1, S_CW, 0, "flush_bubble");
    expect_v(1, S_WHL, 0, "flush_whl");
    step();
    FLUSH = 1'b0;
    CONTROLW_ID = '0;
    chk_hl(32'd100, 32'hFFFF_FFFF, "flush_div");

    issue(mk(ALU_ADDU, MD_MULTU), 32'd5, 32'd5, 0, 0, 7'd0, 8'd0);
    FLUSH = 1'b1;
    expect_v(1, S_WHL, 0, "flush_mult_whl");
    step();
    FLUSH = 1'b0;
    CONTROLW_ID = '0;
    chk_hl(32'd100, 32'hFFFF_FFFF, "flush_mult");

    issue(mk(ALU_ADDU, MD_MULTU), 32'hFFFF_FFFF, 32'd2, 0, 0, 7'd0, 8'd0);
    expect_v(1, S_WHL, 32'd3, "multu_whl");
    chk_hl(32'd1, 32'hFFFF_FFFE, "multu");
    issue(mk(ALU_ADDU, MD_MULT), 32'hFFFF_FFFD, 32'd5, 0, 0, 7'd0, 8'd0);
    chk_hl(32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult");
    issue(mk(ALU_ADDU, MD_MTHI), 0, 0, 32'h1234, 0, 7'd0, 8'd0);
    expect_v(1, S_HL, 32'h1234, "mthi2_memhilo");
    expect_v(1, S_WHL, 32'd2, "mthi2_whl");
    chk_hl(32'h1234, 32'hFFFF_FFF1, "mthi2");

    nop();
    repeat (3) step();

    n_total++;
    if (CONTROLW_EXE === 32'd0) n_pass++;
    else $display("FAIL idle_cw: got %h", CONTROLW_EXE);
    n_total++;
    if (EXEWRITEHILO === 2'b00) n_pass++;
    else $display("FAIL idle_whl: got %b", EXEWRITEHILO);
    n_total++;
    if (EXESTALL === 1'b0) n_pass++;
    else $display("FAIL idle_stall: got %b", EXESTALL);
    n_total++;
    if (dut.hi_q === 32'h1234) n_pass++;
    else $display("FAIL final_hi: got %h", dut.hi_q);
    n_total++;
    if (dut.lo_q === 32'hFFFF_FFF1) n_pass++;
    else $display("FAIL final_lo: got %h", dut.lo_q);

    while (sb.size() > 0) begin
      n_total++;
      $display("FAIL %s: never checked, expected %h at cyc %0d",
               sb[0].nm, sb[0].v, sb[0].at);
      void'(sb.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline, directly upstream of the memory stage. It consumes the ID-stage outputs and produces the registered EXE/MEM bundle the memory stage reads: CONTROLW_EXE, INTCONTROLW_EXE, ALURES, MEMDATA, MEMPC, MEMHILO, EXEDES, EXEWRITEHILO.
- Contains the ALU, the architectural HI/LO registers, and a 1-bit-per-cycle iterative divider. While a divide runs, the divider stalls the front end.

Parameters:
- DIV_CYCLES, 32, number of divider iteration cycles (one quotient bit per cycle).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- FLUSH  in  1  exception flush from CP0; kills the instruction in EXE.
- CONTROLW_ID  in  32  control word. [23:20] ALUOP, [26:24] MDOP, [8] load, [7] store; all other bits pass through untouched.
- INTCONTROLW_ID  in  8  interrupt/exception control from ID.
- SRCA  in  32  operand A (rs; shift amount in [4:0] for shifts).
- SRCB  in  32  operand B (rt or extended immediate, already selected).
- STOREDATA  in  32  rt value for stores / MTHI / MTLO.
- IDPC  in  32  PC of the instruction.
- IDDES  in  7  destination register code; 0 means no write.
- CONTROLW_EXE  out  32  registered control word to MEM.
- INTCONTROLW_EXE  out  8  registered interrupt control; bit 3 is set on arithmetic overflow.
- ALURES  out  32  registered ALU result / data address.
- MEMDATA  out  32  registered STOREDATA.
- MEMPC  out  32  registered IDPC.
- MEMHILO  out  32  registered value written to HI or LO by MTHI/MTLO; 0 otherwise.
- EXEDES  out  7  registered destination.
- EXEWRITEHILO  out  2  registered {HI written, LO written}.
- EXERESULT  out  32  combinational ALU result, used for forwarding to ID.
- EXESTALL  out  1  combinational; holds IF/ID while asserted.

Behaviour:
- Reset:
  - All registered outputs are 0.
  - HI and LO are 0.
  - Divider returns to IDLE.
  - EXESTALL is 0.
- Priority: reset > FLUSH > divider stall > normal advance.
- Normal advance: outputs latch the ID inputs and the ALU result at the rising edge. Latency is 1 cycle.
- ALUOP encoding:
  - 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 AND, 5 OR, 6 XOR, 7 NOR.
  - 8 SLT, 9 SLTU, 10 SLL, 11 SRL, 12 SRA, 13 LUI (SRCB<<16), 14 MFHI, 15 MFLO.
  - Shifts operate on SRCB by SRCA[4:0].
- ADD/SUB signed overflow:
  - ALURES is latched as the wrapped sum.
  - EXEDES is latched as 0.
  - INTCONTROLW_EXE is latched as INTCONTROLW_ID | 8'h08.
  - ADDU/SUBU never flag overflow.
- MDOP encoding: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
- MULT/MULTU:
  - Single cycle; the 64-bit product is written {HI,LO} on the advancing edge.
  - EXEWRITEHILO = 2'b11.
- MTHI/MTLO:
  - Writes STOREDATA to HI or LO.
  - MEMHILO = STOREDATA; EXEWRITEHILO = 2'b10 or 2'b01 respectively.
- MFHI/MFLO read the current HI/LO. An update made by the previous instruction is visible with no hazard.
- Divider FSM:
  - IDLE: a DIV/DIVU instruction is present. Latch |dividend| and |divisor| plus the result sign, set count=0, go to RUN. EXESTALL=1. A bubble is latched to MEM: all outputs 0.
  - RUN: one restoring step per cycle; EXESTALL=1; bubbles continue. When count==DIV_CYCLES-1, go to DONE.
  - DONE: EXESTALL=0. Apply sign correction: quotient sign = sign(A) xor sign(B); remainder sign = sign(A). Write LO=quotient and HI=remainder. Latch the instruction to MEM with EXEWRITEHILO=2'b11. Go to IDLE.
  - Total occupancy is 34 cycles; EXESTALL is high for 33.
- Divide by zero: still 34 cycles. LO=32'hFFFFFFFF, HI=dividend.
- Signed 32'h80000000 / -1: LO=32'h80000000, HI=0.
- FLUSH:
  - Latches a bubble (all outputs 0).
  - Aborts the divider to IDLE with no HI/LO write.
  - Suppresses any MULT/MT HI/LO write in the same cycle.
  - EXESTALL drops the same cycle.
- While EXESTALL=1, the ID inputs are held stable by upstream; this block does not re-sample them after IDLE.

Decomposition:
- Shared package `exe_pkg`:
  - ALUOP and MDOP localparams.
  - Control-word bit positions ([23:20], [26:24], [8], [7]).
  - Overflow exception bit index (3).
  - Divider state encoding.
- Sub-module `exe_divider`:
  - Operands, start, signed, and abort in; quotient, remainder, busy, and done out.
  - Contains the FSM and counter.

Test Plan:
- Reset asserted mid-divide at cycle 10 → next edge: all outputs 0, HI=LO=0, EXESTALL=0.
- ADD 0x7FFFFFFF + 1 → ALURES=0x80000000, EXEDES=0, INTCONTROLW_EXE bit 3 =1. The same operands with ADDU → EXEDES unchanged, bit 3 =0.
- DIV -7 / 2 → EXESTALL high exactly 33 cycles with CONTROLW_EXE=0 throughout, then LO=0xFFFFFFFD, HI=0xFFFFFFFF, EXEWRITEHILO=2'b11. A following MFLO returns 0xFFFFFFFD.
- DIVU 100 / 0 → after 34 cycles LO=0xFFFFFFFF, HI=100.
- FLUSH at RUN cycle 5 of DIV → bubble latched, EXESTALL=0 the same cycle, HI/LO keep their prior values.
- MULTU 0xFFFFFFFF × 2 → HI=1, LO=0xFFFFFFFE in 1 cycle. MTHI 0x1234 → HI=0x1234, MEMHILO=0x1234, EXEWRITEHILO=2'b10.
